com_burst_initiator: RTL and testbench
======================================

Name: com_burst_initiator

Overview:
- Initiator (write-requesting) end of the req/grant/w_en write handshake. The responder FSM owns grant and w_en. This block owns req and wdata.
- A local producer loads up to DEPTH words into an internal burst buffer, then pulses start.
- The block raises req, waits for grant, and presents one buffered word per responder write strobe (w_en).
- It drops req so that the last word goes out with req low, waits out the responder's rest cycles, and reports done.

Parameters:
- DW, 8, width of a data word.
- DEPTH, 8, burst buffer entries; must be a power of two, at least 2.
- CW, 4, width of the count fields; equals log2(DEPTH)+1.
- REST_CYCLES, 2, cool-down cycles after the last word, matching the responder's two rest states.

Ports:
- wclk  in  1  clock; all logic on the rising edge.
- wrst  in  1  synchronous active-high reset.
- ld_en  in  1  load strobe; pushes ld_data into the burst buffer.
- ld_data  in  DW  word to load.
- ld_full  out  1  buffer holds DEPTH words.
- ld_cnt  out  CW  number of words currently loaded.
- start  in  1  launch a burst of ld_cnt words.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a burst completes.
- req  out  1  request to the responder; registered.
- grant  in  1  responder grant.
- w_en  in  1  responder write strobe; the current wdata word is consumed in every cycle it is high during SEND.
- wdata  out  DW  word presented to the responder; equals the buffer entry at rd_ptr.

Behaviour:
- Reset (wrst high at a clock edge, from any state including mid-burst):
  - state=IDLE; req=0, done=0, busy=0, ld_cnt=0, ld_full=0.
  - wr_ptr=0, rd_ptr=0, wdata=0.
  - Buffer contents are don't-care.
- States: IDLE, REQ, SEND, COOL.
- IDLE:
  - ld_en with ld_cnt<DEPTH: buf[wr_ptr]<=ld_data, wr_ptr++, ld_cnt++.
  - ld_en with ld_cnt==DEPTH: ignored; buffer and ld_cnt unchanged.
  - ld_full = (ld_cnt==DEPTH), combinational.
  - start with ld_cnt>0: go to REQ, req<=1, rem<=ld_cnt, rd_ptr<=0.
  - start with ld_cnt==0: ignored; stay in IDLE, no done.
  - start and ld_en in the same cycle: start wins and the load is dropped.
- Loading outside IDLE: ld_en is ignored.
- REQ:
  - Hold req=1 until grant is sampled high, then go to SEND.
  - If rem==1 at that edge, req<=0 (a single-word burst is sent with req low). Otherwise req stays 1.
  - No timeout; REQ waits indefinitely.
- SEND:
  - Each cycle with w_en=1: rd_ptr++, rem--.
  - req<=0 on the edge where w_en=1 and rem==2, so req is low while the final word is presented.
  - w_en=1 with rem==1: final word consumed; go to COOL, cool counter<=REST_CYCLES-1.
  - w_en=0: hold; wdata stable, no change in rem or rd_ptr.
  - grant is ignored in SEND.
- COOL:
  - Count down REST_CYCLES cycles with req=0.
  - On exit to IDLE: done<=1 for one cycle; ld_cnt<=0, wr_ptr<=0, rd_ptr<=0 (buffer emptied).
  - w_en seen during COOL is ignored.
- busy=1 in REQ, SEND and COOL.
- Counter widths: rem, ld_cnt and rd_ptr never wrap within a burst, because a burst is at most DEPTH words.
- wdata = buf[rd_ptr] combinationally in SEND; 0 in all other states.

Test Plan:
- Load 0xA1,0xA2,0xA3, start; grant=1 next cycle, w_en=1 for 3 consecutive cycles:
  - req is high from start until the 0xA2 word is consumed, and low while 0xA3 is presented.
  - wdata sequence is A1,A2,A3.
  - done pulses exactly REST_CYCLES+1 cycles after the last w_en.
  - ld_cnt=0 afterwards.
- Load 1 word 0x5C, start, grant=1: req falls on the grant edge; 0x5C is consumed on the first w_en; done pulses; busy drops.
- Load DEPTH+2 words: ld_full=1 after the 8th load; extra loads are dropped; a burst sends exactly 8 words in load order.
- Stall test: w_en toggles 1,0,0,1,0,1 in SEND with 3 words loaded: wdata holds during the low cycles; exactly 3 words are consumed; no duplicates.
- start with an empty buffer: no req, busy stays 0. Then start and ld_en in the same cycle with 2 words loaded: burst length is 2 and the simultaneous load is dropped.
- Assert wrst during SEND after 1 of 4 words: the next cycle has req=0, busy=0, ld_cnt=0 and no done pulse. A fresh load/start then works normally.

Source files
------------

// File: rtl/com_burst_initiator_if.sv
// Write handshake between the burst initiator and the responder FSM.
// The initiator owns req and wdata; the responder owns grant and w_en.
interface com_burst_initiator_if #(
    parameter int DW = 8
) ();
    logic          req;
    logic          grant;
    logic          w_en;
    logic [DW-1:0] wdata;

    modport master (
        output req,
        output wdata,
        input  grant,
        input  w_en
    );

    modport slave (
        input  req,
        input  wdata,
        output grant,
        output w_en
    );
endinterface

// File: rtl/com_burst_initiator.sv
// Burst write initiator: buffers up to DEPTH words from a local producer,
// then streams them to the responder over the req/grant/w_en handshake.
// req is dropped early so the final word is presented with req low, and
// done pulses once the responder's rest cycles have elapsed.
module com_burst_initiator #(
    parameter int DW          = 8,
    parameter int DEPTH       = 8,
    parameter int CW          = 4,
    parameter int REST_CYCLES = 2
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic                    ld_en,
    input  logic [DW-1:0]           ld_data,
    output logic                    ld_full,
    output logic [CW-1:0]           ld_cnt,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    com_burst_initiator_if.master   bus
);
    localparam int AW = CW - 1;
    localparam int KW = (REST_CYCLES > 1) ? $clog2(REST_CYCLES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] COOL = 2'd3;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);

    logic [1:0]    state;
    logic          req_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] rem;
    logic [KW-1:0] cool;
    logic [DW-1:0] burst_buf [DEPTH];
    logic          load_fire;

    // Loads are accepted only while idle, not full, and not pre-empted by start.
    always_comb begin
        ld_full   = (ld_cnt == CNT_FULL);
        busy      = (state != IDLE);
        load_fire = (state == IDLE) && ld_en && !start && !ld_full;
    end

    assign bus.req   = req_q;
    assign bus.wdata = (state == SEND) ? burst_buf[rd_ptr] : '0;

    // Burst buffer storage; contents need no reset.
    always_ff @(posedge wclk) begin
        if (load_fire) begin
            burst_buf[wr_ptr] <= ld_data;
        end
    end

    // Handshake FSM, load bookkeeping and done pulse.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state  <= IDLE;
            req_q  <= 1'b0;
            done   <= 1'b0;
            ld_cnt <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rem    <= '0;
            cool   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (ld_cnt != '0) begin
                            state  <= REQ;
                            req_q  <= 1'b1;
                            rem    <= ld_cnt;
                            rd_ptr <= '0;
                        end
                    end else if (load_fire) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        ld_cnt <= ld_cnt + CW'(1);
                    end
                end
                REQ: begin
                    if (bus.grant) begin
                        state <= SEND;
                        // A single-word burst goes out entirely with req low.
                        if (rem == CNT_ONE) begin
                            req_q <= 1'b0;
                        end
                    end
                end
                SEND: begin
                    if (bus.w_en) begin
                        rd_ptr <= rd_ptr + AW'(1);
                        rem    <= rem - CNT_ONE;
                        // Drop req one word early so the last word sees req low.
                        if (rem == CNT_TWO) begin
                            req_q <= 1'b0;
                        end
                        if (rem == CNT_ONE) begin
                            state <= COOL;
                            cool  <= KW'(REST_CYCLES - 1);
                        end
                    end
                end
                COOL: begin
                    if (cool == '0) begin
                        state  <= IDLE;
                        done   <= 1'b1;
                        ld_cnt <= '0;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                    end else begin
                        cool <= cool - KW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_com_burst_initiator.sv
// Scoreboard bench for com_burst_initiator: the stimulus side pushes the
// expected word/req pair for each burst entry; a monitor pops and compares
// on every cycle the responder strobes w_en.
module tb_com_burst_initiator;
    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int CW = 4;
    localparam int REST = 2;

    typedef struct {
        logic [DW-1:0] d;
        logic          r;
    } exp_t;

    logic          wclk;
    logic          wrst;
    logic          ld_en;
    logic [DW-1:0] ld_data;
    logic          ld_full;
    logic [CW-1:0] ld_cnt;
    logic          start;
    logic          busy;
    logic          done;

    com_burst_initiator_if #(.DW(DW)) bus ();

    com_burst_initiator #(
        .DW(DW),
        .DEPTH(DEPTH),
        .CW(CW),
        .REST_CYCLES(REST)
    ) dut (
        .wclk(wclk),
        .wrst(wrst),
        .ld_en(ld_en),
        .ld_data(ld_data),
        .ld_full(ld_full),
        .ld_cnt(ld_cnt),
        .start(start),
        .busy(busy),
        .done(done),
        .bus(bus)
    );

    int unsigned checks = 0;
    int unsigned failures = 0;
    exp_t sbq[$];
    logic [DW-1:0] mdl[$];

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] d);
        ld_en = 1'b1;
        ld_data = d;
        tick();
        ld_en = 1'b0;
        if (mdl.size() < DEPTH) mdl.push_back(d);
    endtask

    // Launch a burst of the model's words; pat bit i drives w_en in SEND cycle i.
    task automatic burst(input int npat, input logic [15:0] pat, input logic with_ld);
        int n;
        n = mdl.size();
        start = 1'b1;
        ld_en = with_ld;
        ld_data = 8'h33;
        tick();
        start = 1'b0;
        ld_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.d = mdl[i];
            e.r = (i != n - 1);
            sbq.push_back(e);
        end
        mdl.delete();
        @(negedge wclk);
        check("req_in_REQ", {31'd0, bus.req}, 32'd1);
        check("busy_in_REQ", {31'd0, busy}, 32'd1);
        check("ld_cnt_in_REQ", {28'd0, ld_cnt}, n);
        bus.grant = 1'b1;
        tick();
        bus.grant = 1'b0;
        for (int i = 0; i < npat; i++) begin
            bus.w_en = pat[i];
            @(negedge wclk);
            if (!pat[i] && sbq.size() > 0) check("wdata_hold", {24'd0, bus.wdata}, {24'd0, sbq[0].d});
            tick();
        end
        bus.w_en = 1'b0;
        for (int c = 1; c <= REST + 1; c++) begin
            @(negedge wclk);
            check("done_timing", {31'd0, done}, (c == REST + 1) ? 32'd1 : 32'd0);
            check("busy_cool", {31'd0, busy}, (c <= REST) ? 32'd1 : 32'd0);
            check("req_cool", {31'd0, bus.req}, 32'd0);
            tick();
        end
        @(negedge wclk);
        check("done_single_pulse", {31'd0, done}, 32'd0);
        check("ld_cnt_after", {28'd0, ld_cnt}, 32'd0);
        check("sb_drained", sbq.size(), 32'd0);
    endtask

    // Monitor: every w_en cycle consumes the head of the scoreboard.
    always @(negedge wclk) begin
        if (!wrst && bus.w_en) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: word %0h consumed with nothing expected", bus.wdata);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("wdata", {24'd0, bus.wdata}, {24'd0, e.d});
                check("req_at_word", {31'd0, bus.req}, {31'd0, e.r});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wrst = 1'b1;
        ld_en = 1'b0;
        ld_data = '0;
        start = 1'b0;
        bus.grant = 1'b0;
        bus.w_en = 1'b0;
        tick();
        tick();
        @(negedge wclk);
        check("rst_req", {31'd0, bus.req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ld_cnt", {28'd0, ld_cnt}, 32'd0);
        check("rst_ld_full", {31'd0, ld_full}, 32'd0);
        check("rst_wdata", {24'd0, bus.wdata}, 32'd0);
        wrst = 1'b0;
        tick();

        // Three-word burst, w_en back to back.
        load(8'hA1);
        load(8'hA2);
        load(8'hA3);
        burst(3, 16'b111, 1'b0);

        // Single-word burst: req falls on the grant edge.
        load(8'h5C);
        burst(1, 16'b1, 1'b0);

        // Overfill: ten loads, only eight kept.
        for (int i = 0; i < DEPTH + 2; i++) begin
            load(8'h80 + 8'(i));
            @(negedge wclk);
            check("fill_cnt", {28'd0, ld_cnt}, mdl.size());
            check("fill_full", {31'd0, ld_full}, (mdl.size() == DEPTH) ? 32'd1 : 32'd0);
        end
        burst(8, 16'hFF, 1'b0);

        // Stalled burst: w_en 1,0,0,1,0,1.
        load(8'hC1);
        load(8'hC2);
        load(8'hC3);
        burst(6, 16'b101001, 1'b0);

        // Start with nothing loaded is ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge wclk);
        check("empty_req", {31'd0, bus.req}, 32'd0);
        check("empty_busy", {31'd0, busy}, 32'd0);
        tick();
        @(negedge wclk);
        check("empty_done", {31'd0, done}, 32'd0);

        // start and ld_en together: start wins, the load is dropped.
        load(8'h11);
        load(8'h22);
        burst(2, 16'b11, 1'b1);

        // Reset in the middle of SEND after one of four words.
        load(8'h40);
        load(8'h41);
        load(8'h42);
        load(8'h43);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.d = mdl[i];
            e.r = (i != 3);
            sbq.push_back(e);
        end
        mdl.delete();
        bus.grant = 1'b1;
        tick();
        bus.grant = 1'b0;
        bus.w_en = 1'b1;
        tick();
        bus.w_en = 1'b0;
        wrst = 1'b1;
        tick();
        wrst = 1'b0;
        sbq.delete();
        @(negedge wclk);
        check("mid_rst_req", {31'd0, bus.req}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ld_cnt", {28'd0, ld_cnt}, 32'd0);
        check("mid_rst_wdata", {24'd0, bus.wdata}, 32'd0);
        for (int c = 0; c < REST + 2; c++) begin
            check("mid_rst_no_done", {31'd0, done}, 32'd0);
            tick();
            @(negedge wclk);
        end

        // Fresh burst after reset.
        load(8'h99);
        load(8'h9A);
        burst(2, 16'b11, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
